// File: rtl/char_anim_sequencer.sv
// Character sprite sequencer: picks a sprite id from the registered physics state on each
// animation tick, with landing hold, run-cycle, idle breathing and facing direction.
module char_anim_sequencer #(
    parameter int SIGNED_PHY_WIDTH = 15,
    parameter int CNT_WIDTH        = 6,
    parameter int BREATHE_TICKS    = 16,
    parameter int FALL_HOLD_TICKS  = 32,
    parameter int RUN_FRAMES       = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        character_clk,
    input  logic                        anim_en,
    input  logic [3:0]                  char_state,
    input  logic [SIGNED_PHY_WIDTH-1:0] vel_y,
    output logic [3:0]                  char_display_id,
    output logic                        char_flip,
    output logic                        frame_update
);

    typedef enum logic [3:0] {
        IdleDis1     = 4'd0,
        IdleDis2     = 4'd1,
        ChargeDis    = 4'd2,
        JumpUpDis    = 4'd3,
        JumpDownDis  = 4'd4,
        FallDis      = 4'd5,
        RunDis0      = 4'd6,
        RunDis1      = 4'd7,
        RunDis2      = 4'd8,
        RunDis3      = 4'd9,
        CollisionDis = 4'd10
    } disp_t;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_LEFT      = 4'd1;
    localparam logic [3:0] ST_RIGHT     = 4'd2;
    localparam logic [3:0] ST_CHARGE    = 4'd3;
    localparam logic [3:0] ST_JUMP      = 4'd4;
    localparam logic [3:0] ST_COLLISION = 4'd5;
    localparam logic [3:0] ST_FALL      = 4'd6;
    localparam logic [3:0] ST_HOLD      = 4'd7;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(FALL_HOLD_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] BREATHE_HALF = CNT_WIDTH'(BREATHE_TICKS);
    localparam logic [CNT_WIDTH-1:0] BREATHE_LAST = CNT_WIDTH'(2 * BREATHE_TICKS - 1);
    localparam logic [1:0]           RUN_LAST     = 2'(RUN_FRAMES - 1);

    logic                        r_tick;
    logic                        r_en;
    logic [3:0]                  r_state;
    logic [SIGNED_PHY_WIDTH-1:0] r_vel;

    disp_t                       r_disp, w_disp_d;
    logic                        r_flip, w_flip_d;
    logic                        r_fu, w_fu_d;
    logic [CNT_WIDTH-1:0]        r_hold, w_hold_d;
    logic [CNT_WIDTH-1:0]        r_breathe, w_breathe_d;
    logic [1:0]                  r_run_idx, w_run_idx_d;

    logic                        w_vel_neg;
    logic                        w_vel_zero;
    logic                        w_landing;

    // Sign bit alone decides "<0", so the most-negative code counts as downward.
    assign w_vel_neg  = r_vel[SIGNED_PHY_WIDTH-1];
    assign w_vel_zero = (r_vel == '0);
    assign w_landing  = (r_disp == FallDis) && (r_hold < HOLD_LAST) &&
                        ((r_state == ST_IDLE) || (r_state == ST_HOLD));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tick  <= 1'b0;
            r_en    <= 1'b0;
            r_state <= ST_IDLE;
            r_vel   <= '0;
        end else begin
            r_tick  <= character_clk;
            r_en    <= anim_en;
            r_state <= char_state;
            r_vel   <= vel_y;
        end
    end

    always_comb begin
        w_disp_d    = r_disp;
        w_flip_d    = r_flip;
        w_hold_d    = r_hold;
        w_breathe_d = r_breathe;
        w_run_idx_d = r_run_idx;
        w_fu_d      = 1'b0;
        if (r_tick && r_en) begin
            // Every counter clears unless the branch below advances it.
            w_hold_d    = '0;
            w_breathe_d = '0;
            w_run_idx_d = '0;
            if (w_landing) begin
                w_hold_d = r_hold + 1'b1;
            end else begin
                case (r_state)
                    ST_FALL:      w_disp_d = FallDis;
                    ST_CHARGE:    w_disp_d = ChargeDis;
                    ST_COLLISION: w_disp_d = CollisionDis;
                    ST_LEFT, ST_RIGHT: begin
                        w_disp_d    = disp_t'(4'd6 + {2'b00, r_run_idx});
                        w_run_idx_d = (r_run_idx == RUN_LAST) ? 2'd0 : r_run_idx + 2'd1;
                        w_flip_d    = (r_state == ST_LEFT);
                    end
                    ST_IDLE, ST_JUMP, ST_HOLD: begin
                        if (w_vel_neg) begin
                            w_disp_d = JumpDownDis;
                        end else if (!w_vel_zero) begin
                            w_disp_d = JumpUpDis;
                        end else begin
                            w_disp_d    = (r_breathe < BREATHE_HALF) ? IdleDis1 : IdleDis2;
                            w_breathe_d = (r_breathe == BREATHE_LAST) ? '0 : r_breathe + 1'b1;
                        end
                    end
                    default:      w_disp_d = IdleDis1;
                endcase
            end
            w_fu_d = (w_disp_d != r_disp);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_disp    <= IdleDis1;
            r_flip    <= 1'b0;
            r_fu      <= 1'b0;
            r_hold    <= '0;
            r_breathe <= '0;
            r_run_idx <= '0;
        end else begin
            r_disp    <= w_disp_d;
            r_flip    <= w_flip_d;
            r_fu      <= w_fu_d;
            r_hold    <= w_hold_d;
            r_breathe <= w_breathe_d;
            r_run_idx <= w_run_idx_d;
        end
    end

    assign char_display_id = r_disp;
    assign char_flip       = r_flip;
    assign frame_update    = r_fu;

endmodule

// File: tb/tb_char_anim_sequencer.sv
// Self-checking bench for char_anim_sequencer: directed tables, corner sequences and a
// randomized run against a rule-level reference model.
module tb_char_anim_sequencer;

    localparam int BT = 16;
    localparam int FH = 32;
    localparam int RF = 4;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic               character_clk = 1'b0;
    logic               anim_en = 1'b0;
    logic [3:0]         char_state = 4'd0;
    logic signed [14:0] vel_y = 15'd0;
    logic [3:0]         char_display_id;
    logic               char_flip;
    logic               frame_update;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: registered input copies plus sprite/counter state as plain ints.
    int m_tk, m_en, m_st, m_vel;
    int m_id, m_flip, m_fu, m_hold, m_run, m_br;

    char_anim_sequencer #(
        .SIGNED_PHY_WIDTH(15),
        .CNT_WIDTH(6),
        .BREATHE_TICKS(BT),
        .FALL_HOLD_TICKS(FH),
        .RUN_FRAMES(RF)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .character_clk(character_clk),
        .anim_en(anim_en),
        .char_state(char_state),
        .vel_y(vel_y),
        .char_display_id(char_display_id),
        .char_flip(char_flip),
        .frame_update(frame_update)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tk = 0; m_en = 0; m_st = 0; m_vel = 0;
        m_id = 0; m_flip = 0; m_fu = 0; m_hold = 0; m_run = 0; m_br = 0;
    endtask

    task automatic model_edge();
        int nid, nhold, nrun, nbr;
        if (m_tk != 0 && m_en != 0) begin
            nid = 0; nhold = 0; nrun = 0; nbr = 0;
            if (m_id == 5 && m_hold < FH - 1 && (m_st == 0 || m_st == 7)) begin
                nid = 5;
                nhold = m_hold + 1;
            end else if (m_st == 6) nid = 5;
            else if (m_st == 3) nid = 2;
            else if (m_st == 5) nid = 10;
            else if (m_st == 1 || m_st == 2) begin
                nid = 6 + m_run;
                nrun = (m_run + 1) % RF;
                m_flip = (m_st == 1) ? 1 : 0;
            end else if (m_st == 0 || m_st == 4 || m_st == 7) begin
                if (m_vel > 0) nid = 3;
                else if (m_vel < 0) nid = 4;
                else begin
                    nid = (m_br < BT) ? 0 : 1;
                    nbr = (m_br + 1) % (2 * BT);
                end
            end
            m_fu = (nid != m_id) ? 1 : 0;
            m_id = nid; m_hold = nhold; m_run = nrun; m_br = nbr;
        end else begin
            m_fu = 0;
        end
        m_tk = int'(character_clk);
        m_en = int'(anim_en);
        m_st = int'(char_state);
        m_vel = int'(vel_y);
    endtask

    task automatic cyc(input logic tk, input logic en, input logic [3:0] st,
                       input logic signed [14:0] v);
        character_clk = tk;
        anim_en = en;
        char_state = st;
        vel_y = v;
        @(posedge sys_clk);
        model_edge();
        #1;
    endtask

    // One tick followed by one quiet cycle; outputs then reflect that tick.
    task automatic tick(input logic [3:0] st, input logic signed [14:0] v);
        cyc(1'b1, 1'b1, st, v);
        cyc(1'b0, 1'b1, st, v);
    endtask

    task automatic check_out(input string name, input int id, input int flip, input int fu);
        chk({name, ".id"}, int'(char_display_id), id);
        chk({name, ".flip"}, int'(char_flip), flip);
        chk({name, ".fu"}, int'(frame_update), fu);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #2;
        check_out("reset", 0, 0, 0);
        character_clk = 1'b0; anim_en = 1'b0; char_state = 4'd0; vel_y = 15'd0;
        model_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]         st;
        logic signed [14:0] v;
        int                 id;
        int                 flip;
        int                 fu;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{4'd2,  15'h0000, 6,  0, 1};
        tbl[1]  = '{4'd2,  15'h0000, 7,  0, 1};
        tbl[2]  = '{4'd2,  15'h0000, 8,  0, 1};
        tbl[3]  = '{4'd2,  15'h0000, 9,  0, 1};
        tbl[4]  = '{4'd2,  15'h0000, 6,  0, 1};
        tbl[5]  = '{4'd2,  15'h0000, 7,  0, 1};
        tbl[6]  = '{4'd1,  15'h0000, 8,  1, 1};
        tbl[7]  = '{4'd1,  15'h0000, 9,  1, 1};
        tbl[8]  = '{4'd4,  15'h0005, 3,  1, 1};
        tbl[9]  = '{4'd4,  15'h0000, 0,  1, 1};
        tbl[10] = '{4'd4,  15'h7FFF, 4,  1, 1};
        tbl[11] = '{4'd4,  15'h4000, 4,  1, 0};
        tbl[12] = '{4'd12, 15'h0000, 0,  1, 1};

        model_reset();
        #3;
        do_reset();

        // Run/flip/jump table
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].st, tbl[i].v);
            check_out($sformatf("tbl%0d", i), tbl[i].id, tbl[i].flip, tbl[i].fu);
        end
        tick(4'd0, 15'h0000);
        check_out("flip_persist", 0, 1, 0);

        // Idle breathing over 40 ticks
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick(4'd0, 15'h0000);
            check_out($sformatf("breathe%0d", i), (i >= 16 && i < 32) ? 1 : 0, 0,
                      (i == 16 || i == 32) ? 1 : 0);
        end

        // Landing hold
        do_reset();
        tick(4'd6, 15'h0000);
        check_out("fall_entry", 5, 0, 1);
        for (int i = 0; i < FH - 1; i++) begin
            tick(4'd0, 15'h0000);
            chk($sformatf("hold%0d", i), int'(char_display_id), 5);
        end
        tick(4'd0, 15'h0000);
        check_out("hold_exit", 0, 0, 1);
        tick(4'd6, 15'h0000);
        for (int i = 0; i < 5; i++) tick(4'd7, 15'h0000);
        chk("hold_mid", int'(char_display_id), 5);
        tick(4'd3, 15'h0000);
        check_out("hold_charge", 2, 0, 1);

        // State change on non-tick cycles is deferred to the next tick
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd5, 15'h0000);
        chk("notick_hold", int'(char_display_id), 2);
        tick(4'd5, 15'h0000);
        chk("notick_apply", int'(char_display_id), 10);

        // Freeze with anim_en low mid-run
        do_reset();
        tick(4'd2, 15'h0000);
        tick(4'd2, 15'h0000);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 4'd1, 15'h0000);
            cyc(1'b0, 1'b0, 4'd1, 15'h0000);
        end
        check_out("freeze", 7, 0, 0);
        tick(4'd2, 15'h0000);
        check_out("resume", 8, 0, 1);
        tick(4'd12, 15'h0000);
        check_out("illegal", 0, 0, 1);
        tick(4'd2, 15'h0000);
        chk("run_cleared", int'(char_display_id), 6);

        // Asynchronous reset mid-run at run_idx=2
        do_reset();
        tick(4'd2, 15'h0000);
        tick(4'd2, 15'h0000);
        chk("pre_rst", int'(char_display_id), 7);
        sys_rst_n = 1'b0;
        #2;
        check_out("async_rst", 0, 0, 0);
        model_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        tick(4'd2, 15'h0000);
        check_out("post_rst", 6, 0, 1);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic               tk, en;
            logic [3:0]         st;
            logic signed [14:0] v;
            tk = ($urandom_range(0, 2) == 0);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) st = 4'($urandom_range(8, 15));
            else if ($urandom_range(0, 3) == 0) st = 4'd0;
            else st = 4'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: v = 15'h0001;
                1: v = 15'h7FFF;
                2: v = 15'h4000;
                3: v = 15'h3FFF;
                4: v = 15'($urandom);
                default: v = 15'h0000;
            endcase
            cyc(tk, en, st, v);
            chk("rnd.id", int'(char_display_id), m_id);
            chk("rnd.flip", int'(char_flip), m_flip);
            chk("rnd.fu", int'(frame_update), m_fu);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/char_anim_sequencer.md
CHAR_ANIM_SEQUENCER -- requirements
Module: char_anim_sequencer

Interface
REQ-001 Parameter SIGNED_PHY_WIDTH, default 15, width of the signed vertical velocity input.
REQ-002 Parameter CNT_WIDTH, default 6, width of the internal tick counters.
REQ-003 Parameter BREATHE_TICKS, default 16, idle half-period in ticks; legal range 1 to 2^(CNT_WIDTH-1).
REQ-004 Parameter FALL_HOLD_TICKS, default 32, landing pose hold in ticks; legal range 1 to 2^CNT_WIDTH-1.
REQ-005 Parameter RUN_FRAMES, default 4, run-cycle length; legal range 1 to 4.
REQ-006 sys_clk  input  1  system clock, all logic on the rising edge.
REQ-007 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-008 character_clk  input  1  animation tick, one sys_clk wide pulse.
REQ-009 anim_en  input  1  when low, ticks are ignored and all state freezes.
REQ-010 char_state  input  4  physics state: IDLE=0, LEFT=1, RIGHT=2, CHARGE=3, JUMP=4, COLLISION=5, FALL_TO_GROUND=6, HOLD=7.
REQ-011 vel_y  input  SIGNED_PHY_WIDTH  signed vertical velocity, positive means upward.
REQ-012 char_display_id  output  4  sprite id: IDLE_DIS_1=0, IDLE_DIS_2=1, CHARGE_DIS=2, JUMP_UP_DIS=3, JUMP_DOWN_DIS=4, FALL_DIS=5, RUN_DIS_0..3=6..9, COLLISION_DIS=10.
REQ-013 char_flip  output  1  1 = mirror the sprite horizontally (facing left).
REQ-014 frame_update  output  1  one-cycle pulse when char_display_id changes value.

Function
REQ-015 character_clk, anim_en, char_state and vel_y SHALL be registered once; all decisions use only the registered copies.
REQ-016 char_display_id, char_flip and the counters SHALL update only in cycles where the registered tick AND the registered anim_en are both 1.
REQ-017 Latency: for a tick sampled at edge k, the new char_display_id SHALL be visible after edge k+1.
REQ-018 Decision priority per tick, first match wins:
  - (a) Landing hold: display is FALL_DIS, hold_cnt < FALL_HOLD_TICKS-1, and state is IDLE or HOLD -> stay in FALL_DIS, hold_cnt+1.
  - (b) FALL_TO_GROUND -> FALL_DIS.
  - (c) CHARGE -> CHARGE_DIS.
  - (d) COLLISION -> COLLISION_DIS.
  - (e) LEFT/RIGHT -> RUN_DIS_(run_idx).
  - (f) IDLE/JUMP/HOLD with vel_y>0 -> JUMP_UP_DIS; vel_y<0 -> JUMP_DOWN_DIS.
  - (g) IDLE/JUMP/HOLD with vel_y==0 -> IDLE_DIS_1 if breathe_cnt < BREATHE_TICKS, else IDLE_DIS_2.
  - (h) codes 8-15 -> IDLE_DIS_1, all counters cleared.
REQ-019 hold_cnt SHALL clear to 0 on every tick whose result is not case (a), including entry into FALL_DIS.
REQ-020 run_idx SHALL be 0 on the first run tick after any non-run display, then increment each run tick, wrapping RUN_FRAMES-1 -> 0; it clears on any non-run tick.
REQ-021 breathe_cnt SHALL increment on each case-(g) tick, wrapping 2*BREATHE_TICKS-1 -> 0, and clear on any other tick.
REQ-022 char_flip SHALL be set by a LEFT tick and cleared by a RIGHT tick; all other states hold it.
REQ-023 vel_y comparisons SHALL be signed; the most-negative value counts as <0.
REQ-024 frame_update SHALL be 1 exactly in the cycle after char_display_id changes, otherwise 0; re-selecting the same id SHALL not pulse.
REQ-025 A state change arriving on a non-tick cycle SHALL take effect only at the next tick.

Reset
REQ-026 Assertion of sys_rst_n low SHALL immediately force char_display_id=0, char_flip=0, frame_update=0, all counters and input registers to 0, and the registered char_state to IDLE.
REQ-027 Reset mid-hold or mid-run SHALL discard progress; the first tick after release SHALL follow REQ-018 from cleared counters.

Verification
REQ-028 IDLE, vel_y=0, 40 ticks, defaults -> ids 0 x16, 1 x16, 0 x8; frame_update pulses at each change only.
REQ-029 FALL_TO_GROUND for 1 tick, then IDLE -> id 5 held for 32 ticks total, then 0; a CHARGE tick during the hold -> id 2 on that tick.
REQ-030 RIGHT 6 ticks, then LEFT 2 ticks -> ids 6,7,8,9,6,7 with char_flip=0, then 8,9 with char_flip=1; LEFT persists as flip=1 through later IDLE.
REQ-031 JUMP with vel_y=+5, 0, -1, -16384 on successive ticks -> ids 3, 0, 4, 4.
REQ-032 anim_en=0 for 10 ticks during the run cycle -> no output change; resumes at the next run_idx. char_state=12 -> id 0.
REQ-033 sys_rst_n pulsed low mid-run at run_idx=2 -> all outputs 0 asynchronously; the first RIGHT tick after release gives id 6.
